// File: rtl/cb_pkg.sv
// Shared definitions for the covariance-block (CB) write/read datapath.
//   DIR_*   : 2-bit mode codes carried on the router's sel input.
//   cb_state_e : state encoding of the dinb router's split-beat FSM.
package cb_pkg;

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_POS  = 2'b01;
  localparam logic [1:0] DIR_NEG  = 2'b10;
  localparam logic [1:0] DIR_NEW  = 2'b11;

  typedef enum logic {
    ST_PASS  = 1'b0,  // accepting groups, first beats only
    ST_SPILL = 1'b1   // emitting the residual beat of a row-crossing group
  } cb_state_e;

endpackage

// File: rtl/cb_lane_rotator.sv
// Combinational lane rotator shared by the CB dinb and douta paths.
// Element k of the input (lanes 0..L-1, qualified by mask) is moved to lane
// (shift+k) mod L. Elements that stay within the row (shift+k < L) land in
// the lo_* vectors; elements that wrap past the row end land in hi_*.
// Lanes not written in a vector are driven to 0.
//   data    : L*DW  element vector, element k at [k*DW +: DW]
//   mask    : L     element-valid bits
//   shift   : LW    start lane
//   lo_data/lo_mask : lanes written in the current row
//   hi_data/hi_mask : lanes written in the following row
module cb_lane_rotator #(
  parameter int L  = 4,
  parameter int DW = 16,
  parameter int LW = $clog2(L)
) (
  input  logic [L*DW-1:0] data,
  input  logic [L-1:0]    mask,
  input  logic [LW-1:0]   shift,
  output logic [L*DW-1:0] lo_data,
  output logic [L-1:0]    lo_mask,
  output logic [L*DW-1:0] hi_data,
  output logic [L-1:0]    hi_mask
);

  logic [LW-1:0] src;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves a
    // variable unassigned, which would infer a latch.
    lo_data = '0;
    lo_mask = '0;
    hi_data = '0;
    hi_mask = '0;
    src     = '0;
    for (int j = 0; j < L; j++) begin
      // L is a power of two, so LW-bit subtraction wraps modulo L.
      src = LW'(j) - shift;
      if (mask[src]) begin
        // Destination j below the start lane means the element wrapped.
        if (LW'(j) >= shift) begin
          lo_data[j*DW +: DW] = data[src*DW +: DW];
          lo_mask[j]          = 1'b1;
        end else begin
          hi_data[j*DW +: DW] = data[src*DW +: DW];
          hi_mask[j]          = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cb_dinb_router.sv
// Write-data router from the RSA C-side output lanes to CB BRAM port B.
// Orders a group of lanes (straight for POS, reversed for NEG, landmark pair
// for NEW), places it at a start lane in the L-lane row and emits a per-lane
// write mask. Groups crossing the row end are split: the wrapped part is held
// in a residual register and emitted on the next cycle with out_row_inc=1,
// during which in_ready is low.
//   clk, sys_rst      : clock, synchronous active-high reset
//   sel               : mode (IDLE/POS/NEG/NEW)
//   in_valid/in_ready : group handshake; in_ready depends on FSM state only
//   in_data           : X lanes of RSA_DW bits
//   in_cnt, in_offset : valid lane count and start lane (POS/NEG)
//   landmark_num      : landmark index (NEW)
//   out_valid, out_data, out_we, out_row_inc : registered CB dinb beat
module cb_dinb_router
  import cb_pkg::*;
#(
  parameter int X      = 4,
  parameter int L      = 4,
  parameter int RSA_DW = 16,
  parameter int LW     = $clog2(L),
  parameter int CW     = $clog2(X+1)
) (
  input  logic                clk,
  input  logic                sys_rst,
  input  logic [1:0]          sel,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [X*RSA_DW-1:0] in_data,
  input  logic [CW-1:0]       in_cnt,
  input  logic [LW-1:0]       in_offset,
  input  logic [15:0]         landmark_num,
  output logic                out_valid,
  output logic [L*RSA_DW-1:0] out_data,
  output logic [L-1:0]        out_we,
  output logic                out_row_inc
);

  cb_state_e state_q, state_d;

  logic                accept;
  logic [CW-1:0]       cnt_c;
  logic [L*RSA_DW-1:0] elem;
  logic [L-1:0]        elem_mask;
  logic [LW-1:0]       base;
  logic [L*RSA_DW-1:0] lo_data, hi_data;
  logic [L-1:0]        lo_mask, hi_mask;
  logic                active;
  logic [L*RSA_DW-1:0] res_data;
  logic [L-1:0]        res_we;

  assign accept = in_valid && in_ready;
  // Counts above X are clamped; a zero count yields an empty mask (no-op).
  assign cnt_c  = (in_cnt > CW'(X)) ? CW'(X) : in_cnt;

  // Element ordering and base lane per mode.
  always_comb begin
    elem      = '0;
    elem_mask = '0;
    base      = in_offset;
    unique case (sel)
      DIR_POS: begin
        for (int k = 0; k < X; k++) begin
          if (k < int'(cnt_c)) begin
            elem[k*RSA_DW +: RSA_DW] = in_data[k*RSA_DW +: RSA_DW];
            elem_mask[k]             = 1'b1;
          end
        end
      end
      DIR_NEG: begin
        // Only the valid lanes are reversed: e[k] = lane cnt-1-k.
        for (int k = 0; k < X; k++) begin
          if (k < int'(cnt_c)) begin
            elem[k*RSA_DW +: RSA_DW] =
              in_data[(int'(cnt_c) - 1 - k)*RSA_DW +: RSA_DW];
            elem_mask[k] = 1'b1;
          end
        end
      end
      DIR_NEW: begin
        // Pair lands at (2*landmark_num) mod L; odd landmarks swap the pair.
        base = LW'({landmark_num, 1'b0});
        if (landmark_num[0]) begin
          elem[0*RSA_DW +: RSA_DW] = in_data[1*RSA_DW +: RSA_DW];
          elem[1*RSA_DW +: RSA_DW] = in_data[0*RSA_DW +: RSA_DW];
        end else begin
          elem[0*RSA_DW +: RSA_DW] = in_data[0*RSA_DW +: RSA_DW];
          elem[1*RSA_DW +: RSA_DW] = in_data[1*RSA_DW +: RSA_DW];
        end
        elem_mask[1:0] = 2'b11;
      end
      default: ;  // IDLE: empty mask
    endcase
  end

  cb_lane_rotator #(.L(L), .DW(RSA_DW), .LW(LW)) u_rot (
    .data    (elem),
    .mask    (elem_mask),
    .shift   (base),
    .lo_data (lo_data),
    .lo_mask (lo_mask),
    .hi_data (hi_data),
    .hi_mask (hi_mask)
  );

  assign active = accept && (elem_mask != '0);

  // FSM next state and handshake.
  always_comb begin
    state_d  = state_q;
    in_ready = (state_q == ST_PASS);
    unique case (state_q)
      ST_PASS:  if (active && (hi_mask != '0)) state_d = ST_SPILL;
      ST_SPILL: state_d = ST_PASS;
      default:  state_d = ST_PASS;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (sys_rst) begin
      // NOTE: the residual register is reset along with the outputs so a
      // reset during SPILL cannot leak a stale half-group into the next row.
      state_q     <= ST_PASS;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_we      <= '0;
      out_row_inc <= 1'b0;
      res_data    <= '0;
      res_we      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_SPILL) begin
        out_valid   <= 1'b1;
        out_data    <= res_data;
        out_we      <= res_we;
        out_row_inc <= 1'b1;
        res_data    <= '0;
        res_we      <= '0;
      end else if (active) begin
        out_valid   <= 1'b1;
        out_data    <= lo_data;
        out_we      <= lo_mask;
        out_row_inc <= 1'b0;
        res_data    <= hi_data;
        res_we      <= hi_mask;
      end else begin
        out_valid   <= 1'b0;
        out_data    <= '0;
        out_we      <= '0;
        out_row_inc <= 1'b0;
      end
    end
  end

endmodule
